// File: rtl/mmio_defs.sv
// mmio_defs: MMIO window offsets and status register bit positions.
// The CPU load/writeback select imports this package as well, so the
// offsets are defined in exactly one place.
package mmio_defs;

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RX      = 8'h04;
    localparam logic [7:0] OFF_TX      = 8'h08;
    localparam logic [7:0] OFF_CYCLE   = 8'h10;
    localparam logic [7:0] OFF_INSTRET = 8'h14;
    localparam logic [7:0] OFF_CLEAR   = 8'h18;

    localparam int STAT_TX_READY_BIT    = 0;
    localparam int STAT_RX_NONEMPTY_BIT = 1;

    // Status word layout: {30'b0, rx_nonempty, tx_ready}
    function automatic logic [31:0] pack_status(input logic tx_ready,
                                                input logic rx_nonempty);
        logic [31:0] s;
        s = '0;
        s[STAT_TX_READY_BIT]    = tx_ready;
        s[STAT_RX_NONEMPTY_BIT] = rx_nonempty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// mmio_rx_fifo: byte-wide receive FIFO, DEPTH entries (power of two, >= 2).
// Ports: clk/rst (sync, active high), push/push_data, pop, full, empty,
// head (current oldest byte, valid when !empty).
// Push while full and pop while empty are ignored internally.
module mmio_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head    = mem_q[rd_ptr_q[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: MMIO peripheral block sitting on the CPU execute stage.
// Decodes a 256-byte window at MMIO_BASE: status, UART RX/TX data,
// free-running cycle counter, retired-instruction counter, counter clear.
// Ports: clk/rst (sync, active high); addr/wdata/we/re/inst_retire from
// the CPU; rdata registered to writeback; UART TX/RX valid-ready pairs.
module mmio_ctrl
    import mmio_defs::*;
#(
    parameter int unsigned RX_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    logic        hit, rd_hit, wr_hit;
    logic [7:0]  off;
    logic        tx_ready;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ret_q, ret_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_val;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic        rx_push, rx_pop;
    logic        unused_wdata;

    assign hit    = (addr[31:8] == MMIO_BASE[31:8]);
    assign off    = addr[7:0];
    assign rd_hit = re && hit;
    assign wr_hit = we && hit;

    // TX holding register is empty exactly when nothing is being offered.
    assign tx_ready      = !tx_valid_q;
    assign uart_tx_valid = tx_valid_q;
    assign uart_tx_data  = tx_data_q;

    assign uart_rx_ready = !fifo_full;
    assign rx_push       = uart_rx_valid && !fifo_full;
    assign rx_pop        = rd_hit && (off == OFF_RX) && !fifo_empty;

    assign rdata        = rdata_q;
    assign unused_wdata = ^wdata[31:8];

    mmio_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (uart_rx_data),
        .pop       (rx_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Read mux; write-only and unassigned offsets read as zero.
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_STATUS:  rd_val = pack_status(tx_ready, !fifo_empty);
            OFF_RX:      rd_val = fifo_empty ? 32'h0 : {24'h0, fifo_head};
            OFF_CYCLE:   rd_val = cyc_q;
            OFF_INSTRET: rd_val = ret_q;
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        rdata_d    = rdata_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        cyc_d      = cyc_q + 32'd1;
        ret_d      = ret_q + {31'h0, inst_retire};

        // rdata holds its value across cycles with no decoded load.
        if (rd_hit) rdata_d = rd_val;

        // A store to TX while the holding register is busy is dropped.
        if (tx_valid_q && uart_tx_ready) begin
            tx_valid_d = 1'b0;
        end else if (wr_hit && (off == OFF_TX) && tx_ready) begin
            tx_valid_d = 1'b1;
            tx_data_d  = wdata[7:0];
        end

        // Clear overrides the same-cycle increment.
        if (wr_hit && (off == OFF_CLEAR)) begin
            cyc_d = '0;
            ret_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            cyc_q      <= '0;
            ret_q      <= '0;
        end else begin
            rdata_q    <= rdata_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            cyc_q      <= cyc_d;
            ret_q      <= ret_d;
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: reset, TX handshake and drop, RX FIFO
// fill/drain/refuse, push+pop overlap, counters, clear, wrap, reset flush.
module tb_mmio_ctrl;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        inst_retire = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    int vectors = 0;
    int miscompares = 0;
    int hs_cnt = 0;
    logic [7:0] hs_byte = '0;

    mmio_ctrl #(.RX_DEPTH(4), .MMIO_BASE(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .inst_retire   (inst_retire),
        .rdata         (rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    // Record every completed TX handshake.
    always @(posedge clk) begin
        if (!rst && uart_tx_valid && uart_tx_ready) begin
            hs_cnt  <= hs_cnt + 1;
            hs_byte <= uart_tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_rd(input logic [7:0] o);
        addr = BASE | {24'h0, o};
        re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    task automatic bus_wr(input logic [7:0] o, input logic [31:0] d);
        addr = BASE | {24'h0, o};
        wdata = d;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, uart_tx_data}, 32'h0);
        chk("rst_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        rst = 1'b0;
        bus_rd(8'h10);
        chk("rst_cycle", rdata, 32'h0);
        bus_rd(8'h14);
        chk("rst_instret", rdata, 32'h0);

        // TX: store 0x41 with transmitter stalled
        uart_tx_ready = 1'b0;
        bus_wr(8'h08, 32'hFFFF_FF41);
        chk("tx_valid_1", {31'h0, uart_tx_valid}, 32'h1);
        chk("tx_data_1", {24'h0, uart_tx_data}, 32'h41);
        bus_wr(8'h08, 32'h42);                   // busy: dropped
        chk("tx_valid_2", {31'h0, uart_tx_valid}, 32'h1);
        chk("tx_drop_data", {24'h0, uart_tx_data}, 32'h41);
        bus_rd(8'h00);
        chk("status_busy", rdata, 32'h0);
        chk("tx_valid_3", {31'h0, uart_tx_valid}, 32'h1);
        uart_tx_ready = 1'b1;
        chk("tx_valid_4", {31'h0, uart_tx_valid}, 32'h1);
        tick();
        uart_tx_ready = 1'b0;
        chk("tx_valid_drop", {31'h0, uart_tx_valid}, 32'h0);
        bus_rd(8'h00);
        chk("status_idle", rdata, 32'h1);
        chk("tx_hs_count", hs_cnt, 32'd1);
        chk("tx_hs_byte", {24'h0, hs_byte}, 32'h41);
        // rdata holds across idle cycles and accesses outside the window
        tick();
        chk("rdata_hold", rdata, 32'h1);
        addr = 32'h0000_0004; re = 1'b1; tick(); re = 1'b0;
        chk("rdata_nodecode", rdata, 32'h1);

        // RX: fill to depth, refuse fifth byte
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_rx_data = 8'h10 + 8'(i);
            tick();
        end
        uart_rx_data = 8'h14;
        chk("rx_full_ready", {31'h0, uart_rx_ready}, 32'h0);
        tick();
        uart_rx_valid = 1'b0;
        bus_rd(8'h00);
        chk("status_rx_full", rdata, 32'h3);
        for (int i = 0; i < 4; i++) begin
            bus_rd(8'h04);
            chk($sformatf("rx_pop_%0d", i), rdata, 32'h10 + 32'(i));
        end
        bus_rd(8'h04);
        chk("rx_pop_empty", rdata, 32'h0);
        bus_rd(8'h00);
        chk("status_rx_empty", rdata, 32'h1);
        chk("rx_ready_again", {31'h0, uart_rx_ready}, 32'h1);

        // Simultaneous push and pop with one entry held
        uart_rx_valid = 1'b1; uart_rx_data = 8'hAA;
        tick();
        uart_rx_data = 8'h55;
        addr = BASE | 32'h04; re = 1'b1;
        tick();
        re = 1'b0; uart_rx_valid = 1'b0;
        chk("pushpop_old_head", rdata, 32'hAA);
        bus_rd(8'h04);
        chk("pushpop_new", rdata, 32'h55);
        bus_rd(8'h04);
        chk("pushpop_occ1", rdata, 32'h0);

        // Cycle counter wrap and zero-reading offsets
        force dut.cyc_q = 32'hFFFF_FFFF;
        bus_rd(8'h10);
        chk("cyc_max", rdata, 32'hFFFF_FFFF);
        chk("cyc_wrap_next", dut.cyc_d, 32'h0);
        release dut.cyc_q;
        bus_rd(8'h0C);
        chk("rd_0c_zero", rdata, 32'h0);
        bus_rd(8'h00);
        bus_rd(8'h08);
        chk("rd_08_zero", rdata, 32'h0);
        bus_rd(8'h00);
        bus_rd(8'h18);
        chk("rd_18_zero", rdata, 32'h0);

        // Counters: clear, 100 cycles with 37 retires
        bus_wr(8'h18, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i < 74) && (i % 2 == 0);
            tick();
        end
        inst_retire = 1'b0;
        bus_rd(8'h10);
        chk("cyc_100", rdata, 32'd100);
        bus_rd(8'h14);
        chk("ret_37", rdata, 32'd37);
        bus_rd(8'h10);
        chk("cyc_102", rdata, 32'd102);
        // Store to read-only counter offset is ignored
        bus_wr(8'h14, 32'h1234);
        bus_rd(8'h14);
        chk("ret_ro", rdata, 32'd37);
        // Clear coincident with a retire pulse, and re/we in one cycle
        inst_retire = 1'b1;
        addr = BASE | 32'h18; wdata = 32'h0; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0; inst_retire = 1'b0;
        bus_rd(8'h10);
        chk("clr_cyc", rdata, 32'h0);
        bus_rd(8'h14);
        chk("clr_ret", rdata, 32'h0);

        // Reset mid-handshake with FIFO data
        bus_wr(8'h08, 32'h77);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
        tick();
        uart_rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("rst2_tx_data", {24'h0, uart_tx_data}, 32'h0);
        chk("rst2_rdata", rdata, 32'h0);
        bus_rd(8'h00);
        chk("rst2_status", rdata, 32'h1);
        bus_rd(8'h04);
        chk("rst2_rx_empty", rdata, 32'h0);
        chk("rst2_hs_count", hs_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
